// File: rtl/pio_mailbox_ctrl.sv
// Host PIO command sequencer: captures a toggled command word, drives LEDs/hex display,
// reports debounced sticky button events, and answers with a toggled status word.
module pio_mailbox_ctrl #(
  parameter int          NUM_BUTTONS     = 4,
  parameter int          DEBOUNCE_CYCLES = 50000,
  parameter logic [27:0] VERSION         = 28'h0001000
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [31:0]            cmd_word,
  output logic [31:0]            status_word,
  input  logic [NUM_BUTTONS-1:0] buttons_n,
  output logic [31:0]            led_red,
  output logic [31:0]            led_green,
  output logic [31:0]            hex_value,
  output logic                   busy
);

  localparam int CW = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;

  typedef enum logic [1:0] {IDLE, DECODE, EXEC, RESP} state_t;

  state_t                 state, state_nxt;
  logic                   capture;
  logic                   last_tog;
  logic [31:0]            cmd_q;
  logic [27:0]            data_q;
  logic                   err_q;

  logic [2:0]             opcode;
  logic [23:0]            payload;
  logic                   cmd_err;
  logic [27:0]            exec_data;
  logic [31:0]            hex_lo_nxt, hex_hi_nxt;
  logic                   clr_events;

  logic [NUM_BUTTONS-1:0] sync1, sync2, level, events;
  logic [NUM_BUTTONS-1:0] accept, press, pressed_lvl;
  logic [CW-1:0]          cnt [NUM_BUTTONS];

  logic                   unused_payload;
  assign unused_payload = ^cmd_q[23:18];

  assign opcode      = cmd_q[30:28];
  assign payload     = cmd_q[23:0];
  assign cmd_err     = |cmd_q[27:24];
  assign hex_lo_nxt  = {hex_value[31:16], payload[15:0]};
  assign hex_hi_nxt  = {payload[15:0], hex_value[15:0]};
  assign pressed_lvl = ~level;
  assign busy        = (state != IDLE);

  always_comb begin
    state_nxt = state;
    capture   = 1'b0;
    case (state)
      IDLE: begin
        if (cmd_word[31] != last_tog) begin
          state_nxt = DECODE;
          capture   = 1'b1;
        end
      end
      DECODE:  state_nxt = EXEC;
      EXEC:    state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    exec_data  = '0;
    clr_events = 1'b0;
    case (opcode)
      3'd1: exec_data = 28'(payload[17:0]);
      3'd2: exec_data = 28'(payload[8:0]);
      3'd3: exec_data = hex_lo_nxt[27:0];
      3'd4: exec_data = hex_hi_nxt[27:0];
      3'd5: begin
        exec_data  = 28'(events);
        clr_events = (state == EXEC);
      end
      3'd6: exec_data = 28'(pressed_lvl);
      3'd7: exec_data = VERSION;
      default: exec_data = '0;
    endcase
    if (cmd_err) begin
      exec_data  = '0;
      clr_events = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      last_tog    <= 1'b0;
      cmd_q       <= '0;
      data_q      <= '0;
      err_q       <= 1'b0;
      status_word <= '0;
      led_red     <= '0;
      led_green   <= '0;
      hex_value   <= '0;
    end else begin
      state <= state_nxt;
      if (capture) begin
        cmd_q    <= cmd_word;
        last_tog <= cmd_word[31];
      end
      if (state == EXEC) begin
        data_q <= exec_data;
        err_q  <= cmd_err;
        if (!cmd_err) begin
          case (opcode)
            3'd1:    led_red   <= 32'(payload[17:0]);
            3'd2:    led_green <= 32'(payload[8:0]);
            3'd3:    hex_value <= hex_lo_nxt;
            3'd4:    hex_value <= hex_hi_nxt;
            default: ;
          endcase
        end
      end
      if (state == RESP)
        status_word <= {cmd_q[31], err_q, 2'b00, data_q};
    end
  end

  // A level is accepted only after DEBOUNCE_CYCLES consecutive cycles of disagreement.
  always_comb begin
    for (int b = 0; b < NUM_BUTTONS; b++) begin
      accept[b] = (sync2[b] != level[b]) && (cnt[b] == CW'(DEBOUNCE_CYCLES - 1));
      press[b]  = accept[b] && !sync2[b];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1  <= '1;
      sync2  <= '1;
      level  <= '1;
      events <= '0;
      for (int b = 0; b < NUM_BUTTONS; b++)
        cnt[b] <= '0;
    end else begin
      sync1 <= buttons_n;
      sync2 <= sync1;
      // A press accepted during the read-and-clear cycle survives the clear.
      events <= (clr_events ? '0 : events) | press;
      for (int b = 0; b < NUM_BUTTONS; b++) begin
        if (sync2[b] == level[b]) begin
          cnt[b] <= '0;
        end else if (accept[b]) begin
          cnt[b]   <= '0;
          level[b] <= sync2[b];
        end else begin
          cnt[b] <= cnt[b] + CW'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_pio_mailbox_ctrl.sv
// Bench for pio_mailbox_ctrl: directed scenarios with literal expectations, then random
// traffic, all compared every cycle against a transaction-level model.
module tb_pio_mailbox_ctrl;

  localparam int          NB  = 4;
  localparam int          D   = 8;
  localparam logic [27:0] VER = 28'h0001000;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic [31:0]   cmd_word = '0;
  logic [NB-1:0] buttons_n = '1;
  logic [31:0]   status_word, led_red, led_green, hex_value;
  logic          busy;

  int checks = 0;
  int fails  = 0;

  pio_mailbox_ctrl #(.NUM_BUTTONS(NB), .DEBOUNCE_CYCLES(D), .VERSION(VER)) dut (
    .clk(clk), .reset(reset), .cmd_word(cmd_word), .status_word(status_word),
    .buttons_n(buttons_n), .led_red(led_red), .led_green(led_green),
    .hex_value(hex_value), .busy(busy)
  );

  always #5 clk = ~clk;

  // Model: a command is in flight for three edges after capture; its effects land on the
  // second edge and its status on the third. Buttons are tracked as run lengths of disagreement.
  logic [31:0]   m_status, m_red, m_green, m_hex, m_cq;
  logic          m_last, m_busy, m_err, m_clr;
  int            m_age;
  logic [27:0]   m_data;
  logic [NB-1:0] m_s1, m_s2, m_lvl, m_ev, m_new, m_inv;
  int            m_run [NB];

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_status = '0; m_red = '0; m_green = '0; m_hex = '0; m_cq = '0;
      m_last = 1'b0; m_busy = 1'b0; m_err = 1'b0; m_age = 0; m_data = '0;
      m_s1 = '1; m_s2 = '1; m_lvl = '1; m_ev = '0;
      for (int b = 0; b < NB; b++) m_run[b] = 0;
    end else begin
      m_clr = 1'b0;
      if (m_busy) begin
        m_age++;
        if (m_age == 2) begin
          m_err  = |m_cq[27:24];
          m_data = '0;
          if (!m_err) begin
            case (m_cq[30:28])
              3'd1: begin m_red = {14'b0, m_cq[17:0]}; m_data = m_red[27:0]; end
              3'd2: begin m_green = {23'b0, m_cq[8:0]}; m_data = m_green[27:0]; end
              3'd3: begin m_hex[15:0] = m_cq[15:0]; m_data = m_hex[27:0]; end
              3'd4: begin m_hex[31:16] = m_cq[15:0]; m_data = m_hex[27:0]; end
              3'd5: begin m_data = {{(28-NB){1'b0}}, m_ev}; m_clr = 1'b1; end
              3'd6: begin m_inv = ~m_lvl; m_data = {{(28-NB){1'b0}}, m_inv}; end
              3'd7: m_data = VER;
              default: m_data = '0;
            endcase
          end
        end else if (m_age == 3) begin
          m_status = {m_cq[31], m_err, 2'b00, m_data};
          m_busy   = 1'b0;
        end
      end else if (cmd_word[31] != m_last) begin
        m_cq = cmd_word; m_last = cmd_word[31]; m_busy = 1'b1; m_age = 0;
      end
      m_new = '0;
      for (int b = 0; b < NB; b++) begin
        if (m_s2[b] != m_lvl[b]) begin
          m_run[b]++;
          if (m_run[b] == D) begin
            m_lvl[b] = m_s2[b];
            m_run[b] = 0;
            if (!m_lvl[b]) m_new[b] = 1'b1;
          end
        end else begin
          m_run[b] = 0;
        end
      end
      m_ev = (m_clr ? '0 : m_ev) | m_new;
      m_s2 = m_s1;
      m_s1 = buttons_n;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    check("status_word", status_word, m_status);
    check("led_red", led_red, m_red);
    check("led_green", led_green, m_green);
    check("hex_value", hex_value, m_hex);
    check("busy", {31'b0, busy}, {31'b0, m_busy});
  end

  task automatic send(input logic [31:0] w, output int bc);
    @(posedge clk);
    #2 cmd_word = w;
    bc = 0;
    repeat (6) begin
      @(negedge clk);
      if (busy) bc++;
    end
  endtask

  task automatic btn(input int b, input logic v);
    @(posedge clk);
    #2 buttons_n[b] = v;
  endtask

  int bc;
  int r;
  logic [31:0] w;

  initial begin
    #1 reset = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_status", status_word, 32'h0);
    check("reset_busy", {31'b0, busy}, 32'h0);
    check("reset_hex", hex_value, 32'h0);
    #2 reset = 1'b0;

    send(32'h1000_0ABC, bc);
    check("no_toggle_busy", bc, 0);
    check("no_toggle_led_red", led_red, 32'h0);

    send(32'h9000_0ABC, bc);
    check("op1_busy_cycles", bc, 3);
    check("op1_led_red", led_red, 32'h0000_0ABC);
    check("op1_status", status_word, 32'h8000_0ABC);

    send(32'h0000_0000, bc);
    check("nop_status", status_word, 32'h0000_0000);
    send(32'hB000_1234, bc);
    send(32'h4000_ABCD, bc);
    check("hex_value", hex_value, 32'hABCD_1234);
    check("hex_status", status_word, 32'h0BCD_1234);

    send(32'h9100_0000, bc);
    check("err_status", status_word, 32'hC000_0000);
    check("err_led_red", led_red, 32'h0000_0ABC);
    check("err_hex", hex_value, 32'hABCD_1234);

    btn(2, 1'b0); repeat (D + 4) @(posedge clk);
    btn(2, 1'b1); repeat (D + 4) @(posedge clk);
    send(32'h5000_0000, bc);
    check("event_read", status_word, 32'h0000_0004);
    send(32'hD000_0000, bc);
    check("event_cleared", status_word, 32'h8000_0000);

    btn(0, 1'b0); repeat (D - 3) @(posedge clk);
    btn(0, 1'b1); repeat (2 * D) @(posedge clk);
    send(32'h5000_0000, bc);
    check("glitch_no_event", status_word, 32'h0000_0000);

    btn(3, 1'b0); repeat (D + 4) @(posedge clk);
    send(32'hE000_0000, bc);
    check("live_level", status_word, 32'h8000_0008);
    btn(3, 1'b1); repeat (D + 4) @(posedge clk);
    send(32'h5000_0000, bc);
    check("event_after_live", status_word, 32'h0000_0008);
    send(32'hF000_0000, bc);
    check("version", status_word, 32'h8000_1000);

    btn(1, 1'b0); repeat (D - 2) @(posedge clk);
    send(32'h5000_0000, bc);
    check("collision_excluded", status_word, 32'h0000_0000);
    send(32'hD000_0000, bc);
    check("collision_kept", status_word, 32'h8000_0002);
    btn(1, 1'b1); repeat (D + 4) @(posedge clk);

    send(32'h2000_0055, bc);
    check("op2_led_green", led_green, 32'h0000_0055);
    @(posedge clk); #2 cmd_word = 32'hA000_01FF;
    @(posedge clk); @(posedge clk);
    #2 reset = 1'b1;
    repeat (2) @(negedge clk);
    check("midreset_led_green", led_green, 32'h0);
    check("midreset_status", status_word, 32'h0);
    check("midreset_led_red", led_red, 32'h0);
    @(posedge clk); #2 reset = 1'b0;
    repeat (8) @(negedge clk);
    check("post_reset_led_green", led_green, 32'h0000_01FF);
    check("post_reset_status", status_word, 32'h8000_01FF);

    for (int i = 0; i < 250; i++) begin
      r = $urandom_range(0, 11);
      if (r <= 6) begin
        w = $urandom;
        w[31] = $urandom_range(0, 1);
        if ($urandom_range(0, 7) != 0) w[27:24] = 4'h0;
        @(posedge clk); #2 cmd_word = w;
        repeat ($urandom_range(0, 6)) @(posedge clk);
      end else if (r <= 10) begin
        btn($urandom_range(0, NB - 1), 1'($urandom_range(0, 1)));
        repeat ($urandom_range(1, 2 * D)) @(posedge clk);
      end else begin
        @(posedge clk); #2 reset = 1'b1;
        repeat ($urandom_range(1, 2)) @(posedge clk);
        #2 reset = 1'b0;
      end
    end
    @(posedge clk); #2 buttons_n = '1;
    repeat (3 * D) @(posedge clk);
    @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
